pipeline_ctrl: RTL

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_if.sv | 72 +++++++
 rtl/pipeline_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_if
//
// Purpose: groups the signals exchanged between the five-stage datapath and
// the pipeline hazard controller. The datapath (master) reports fetch/data
// completion and the hazard-relevant fields of the ID/EX/MEM stages. The
// controller (slave) returns the PC enable, latch enables/flushes, the halt
// flag and the stall counter.
//
// Signal summary
//   datapath -> controller
//     ihit            instruction fetch for current PC completes this cycle
//     dhit            MEM-stage data access completes this cycle
//     mem_dREN        MEM-stage load pending
//     mem_dWEN        MEM-stage store pending
//     mem_redirect    branch taken / jump resolved in MEM
//     mem_hlt         halt instruction in MEM
//     ex_dREN         EX-stage instruction is a load
//     ex_regen        EX-stage register write enable
//     ex_wsel[4:0]    EX-stage destination register
//     id_rsel1[4:0]   ID-stage source register 1
//     id_rsel2[4:0]   ID-stage source register 2
//   controller -> datapath
//     pc_en                                   PC update enable
//     ifid_en, idex_en, exmem_en, memwb_en    pipeline latch enables
//     ifid_flush .. memwb_flush               latch clears (override enable)
//     halt                                    processor halted (registered)
//     stall_cnt[31:0]                         saturating stall-cycle count
// ---------------------------------------------------------------------------
interface pipeline_ctrl_if;
  logic        ihit;
  logic        dhit;
  logic        mem_dREN;
  logic        mem_dWEN;
  logic        mem_redirect;
  logic        mem_hlt;
  logic        ex_dREN;
  logic        ex_regen;
  logic [4:0]  ex_wsel;
  logic [4:0]  id_rsel1;
  logic [4:0]  id_rsel2;

  logic        pc_en;
  logic        ifid_en;
  logic        idex_en;
  logic        exmem_en;
  logic        memwb_en;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_flush;
  logic        memwb_flush;
  logic        halt;
  logic [31:0] stall_cnt;

  // Datapath side
  modport master (
    output ihit, dhit, mem_dREN, mem_dWEN, mem_redirect, mem_hlt,
           ex_dREN, ex_regen, ex_wsel, id_rsel1, id_rsel2,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           halt, stall_cnt
  );

  // Controller side
  modport slave (
    input  ihit, dhit, mem_dREN, mem_dWEN, mem_redirect, mem_hlt,
           ex_dREN, ex_regen, ex_wsel, id_rsel1, id_rsel2,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           halt, stall_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
//
// Purpose: hazard / stall controller for a five-stage pipeline. Decides each
// cycle whether the PC advances, which pipeline latches capture and which
// are cleared to insert bubbles, tracks a data-miss wait and a terminal
// halted state, and counts stall cycles.
//
// Ports
//   CLK   in   system clock (rising edge)
//   nRST  in   synchronous active-low reset
//   pif   slave modport of pipeline_ctrl_if (see interface header)
//
// Decision priority while running (first match wins, anything not named
// is enabled and not flushed):
//   1. halt in MEM      freeze PC..EX/MEM, let MEM/WB retire, go HALTED
//   2. data miss        freeze PC..EX/MEM, bubble into MEM/WB, go DWAIT
//   3. redirect         load new PC, squash IF/ID, ID/EX, EX/MEM
//   4. load-use         hold PC and IF/ID, bubble into ID/EX
//   5. fetch miss       hold PC, bubble into IF/ID
//   6. otherwise        everything advances
// ---------------------------------------------------------------------------
module pipeline_ctrl (
  input  logic           CLK,
  input  logic           nRST,
  pipeline_ctrl_if.slave pif
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [31:0] stall_cnt_reg;

  logic        dmiss;
  logic        lduse;

  logic        pc_en_c;
  logic        ifid_en_c;
  logic        idex_en_c;
  logic        exmem_en_c;
  logic        memwb_en_c;
  logic        ifid_flush_c;
  logic        idex_flush_c;
  logic        exmem_flush_c;
  logic        memwb_flush_c;

  // Hazard detection. r0 is hardwired to zero, so a load targeting it can
  // never feed a dependent instruction.
  assign dmiss = (pif.mem_dREN | pif.mem_dWEN) & ~pif.dhit;
  assign lduse = pif.ex_dREN & pif.ex_regen & (pif.ex_wsel != 5'd0) &
                 ((pif.ex_wsel == pif.id_rsel1) | (pif.ex_wsel == pif.id_rsel2));

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic. DWAIT decodes exactly like RUN: while the miss is
  // still outstanding it stays, and the dhit cycle falls through to RUN.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN, DWAIT: begin
        if (pif.mem_hlt) begin
          state_next = HALTED;
        end else if (dmiss) begin
          state_next = DWAIT;
        end else begin
          state_next = RUN;
        end
      end
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic. Reset overrides state so the datapath sees bubbles in
  // every latch even before the state register has been initialised.
  // -------------------------------------------------------------------------
  always_comb begin
    pc_en_c       = 1'b1;
    ifid_en_c     = 1'b1;
    idex_en_c     = 1'b1;
    exmem_en_c    = 1'b1;
    memwb_en_c    = 1'b1;
    ifid_flush_c  = 1'b0;
    idex_flush_c  = 1'b0;
    exmem_flush_c = 1'b0;
    memwb_flush_c = 1'b0;

    if (!nRST) begin
      pc_en_c       = 1'b0;
      ifid_en_c     = 1'b0;
      idex_en_c     = 1'b0;
      exmem_en_c    = 1'b0;
      memwb_en_c    = 1'b0;
      ifid_flush_c  = 1'b1;
      idex_flush_c  = 1'b1;
      exmem_flush_c = 1'b1;
      memwb_flush_c = 1'b1;
    end else begin
      case (state_reg)
        RUN, DWAIT: begin
          if (pif.mem_hlt) begin
            // Let the halt instruction's predecessor in MEM/WB retire.
            pc_en_c    = 1'b0;
            ifid_en_c  = 1'b0;
            idex_en_c  = 1'b0;
            exmem_en_c = 1'b0;
          end else if (dmiss) begin
            // Front of the pipe frozen; WB must not repeat the old result.
            pc_en_c       = 1'b0;
            ifid_en_c     = 1'b0;
            idex_en_c     = 1'b0;
            exmem_en_c    = 1'b0;
            memwb_flush_c = 1'b1;
          end else if (pif.mem_redirect) begin
            // PC mux already points at the target; squash wrong-path work.
            ifid_flush_c  = 1'b1;
            idex_flush_c  = 1'b1;
            exmem_flush_c = 1'b1;
          end else if (lduse) begin
            pc_en_c      = 1'b0;
            ifid_en_c    = 1'b0;
            idex_flush_c = 1'b1;
          end else if (!pif.ihit) begin
            pc_en_c      = 1'b0;
            ifid_flush_c = 1'b1;
          end
        end
        HALTED: begin
          pc_en_c    = 1'b0;
          ifid_en_c  = 1'b0;
          idex_en_c  = 1'b0;
          exmem_en_c = 1'b0;
          memwb_en_c = 1'b0;
        end
        default: begin
          // Unreachable encoding: hold everything and insert bubbles.
          pc_en_c       = 1'b0;
          ifid_en_c     = 1'b0;
          idex_en_c     = 1'b0;
          exmem_en_c    = 1'b0;
          memwb_en_c    = 1'b0;
          ifid_flush_c  = 1'b1;
          idex_flush_c  = 1'b1;
          exmem_flush_c = 1'b1;
          memwb_flush_c = 1'b1;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Stall counter: cycles where the PC did not advance while the machine was
  // still live. Holds at all-ones rather than wrapping.
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stall_cnt_reg <= 32'd0;
    end else if ((state_reg != HALTED) && !pc_en_c && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign pif.pc_en       = pc_en_c;
  assign pif.ifid_en     = ifid_en_c;
  assign pif.idex_en     = idex_en_c;
  assign pif.exmem_en    = exmem_en_c;
  assign pif.memwb_en    = memwb_en_c;
  assign pif.ifid_flush  = ifid_flush_c;
  assign pif.idex_flush  = idex_flush_c;
  assign pif.exmem_flush = exmem_flush_c;
  assign pif.memwb_flush = memwb_flush_c;
  // Derived from the state register, so it is registered by construction.
  assign pif.halt        = (state_reg == HALTED);
  assign pif.stall_cnt   = stall_cnt_reg;

endmodule
